// File: rtl/conv_job_scheduler.sv
// rtl/conv_job_scheduler.sv - two-requester job front end for the 2D convolution engine
// Arbitrates, validates geometry, computes O by repeated subtraction, then loads/runs the engine.
module conv_job_scheduler #(
  parameter int Width   = 16,
  parameter int TIMEOUT = 8191
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  input  logic [23:0]      req0_cfg,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [23:0]      req1_cfg,
  output logic             req1_ready,
  output logic             fetch_sel,
  output logic [5:0]       fetch_addr,
  output logic             fetch_a_en,
  output logic             fetch_b_en,
  input  logic [Width-1:0] mem_a_rdata,
  input  logic [Width-1:0] mem_b_rdata,
  output logic             eng_rst,
  output logic [5:0]       eng_N1,
  output logic [5:0]       eng_M1,
  output logic [5:0]       eng_S1,
  output logic [5:0]       eng_P1,
  output logic [5:0]       eng_O1,
  output logic [Width-1:0] eng_a_in,
  output logic [Width-1:0] eng_b_in,
  input  logic [Width-1:0] eng_final_out,
  input  logic             eng_done,
  output logic             res_valid,
  output logic [Width-1:0] res_data,
  output logic             res_id,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [1:0]       resp_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DIV, S_REJECT, S_ENG_RST, S_LOAD, S_RUN, S_RESP
  } state_t;

  localparam logic [12:0] TMO_LAST = 13'(TIMEOUT - 1);

  state_t      state, state_n;
  logic        prefer, grant_r;
  logic [5:0]  n_r, m_r, s_r, p_r, o_r, q_r;
  logic [7:0]  rem_r;
  logic [6:0]  k_r, beats_r;
  logic [12:0] tcnt_r;
  logic        seen_r;
  logic [1:0]  err_r;

  logic        any_req, gnt;
  logic [23:0] cfg_sel;
  logic [7:0]  np;
  logic [15:0] np_sq;
  logic [11:0] m_sq, n_sq, o_sq, o_next_sq;
  logic [5:0]  o_next;
  logic        cfg_bad, div_step, run_done, run_tmo;

  // Both requesting: serve the one not served last; otherwise serve whoever asks.
  assign any_req = (req0_valid | req1_valid) & ~RST;
  assign gnt     = (req0_valid & req1_valid) ? prefer : ~req0_valid;
  assign cfg_sel = gnt ? req1_cfg : req0_cfg;

  assign np        = {2'b00, n_r} + {1'b0, p_r, 1'b0};
  assign np_sq     = {8'd0, np} * {8'd0, np};
  assign m_sq      = {6'd0, m_r} * {6'd0, m_r};
  assign n_sq      = {6'd0, n_r} * {6'd0, n_r};
  assign o_sq      = {6'd0, o_r} * {6'd0, o_r};
  assign o_next    = q_r + 6'd1;
  assign o_next_sq = {6'd0, o_next} * {6'd0, o_next};
  assign cfg_bad   = (n_r == 6'd0) || (m_r == 6'd0) || (s_r == 6'd0) ||
                     ({2'b00, m_r} > np) || (np_sq > 16'd64) || (m_sq > 12'd64);
  assign div_step  = rem_r >= {2'b00, s_r};
  assign run_done  = eng_done && (({5'd0, beats_r} + 12'd1) == o_sq);
  assign run_tmo   = ~eng_done & ~seen_r & (tcnt_r == TMO_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      prefer  <= 1'b0;
      grant_r <= 1'b0;
      n_r     <= '0;
      m_r     <= '0;
      s_r     <= '0;
      p_r     <= '0;
      o_r     <= '0;
      q_r     <= '0;
      rem_r   <= '0;
      k_r     <= '0;
      beats_r <= '0;
      tcnt_r  <= '0;
      seen_r  <= 1'b0;
      err_r   <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant_r <= gnt;
            prefer  <= ~gnt;
            {n_r, m_r, s_r, p_r} <= cfg_sel;
          end
        end
        S_CHECK: begin
          rem_r <= np - {2'b00, m_r};
          q_r   <= '0;
        end
        S_DIV: begin
          if (div_step) begin
            rem_r <= rem_r - {2'b00, s_r};
            q_r   <= q_r + 6'd1;
          end else begin
            o_r <= o_next;
          end
        end
        S_ENG_RST: begin
          k_r     <= '0;
          beats_r <= '0;
          tcnt_r  <= '0;
          seen_r  <= 1'b0;
        end
        S_LOAD: k_r <= k_r + 7'd1;
        S_RUN: begin
          // The watchdog only guards the wait for the first result beat.
          if (eng_done) begin
            beats_r <= beats_r + 7'd1;
            seen_r  <= 1'b1;
          end else if (!seen_r) begin
            tcnt_r <= tcnt_r + 13'd1;
          end
          err_r <= run_tmo ? 2'd2 : 2'd0;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    fetch_a_en = 1'b0;
    fetch_b_en = 1'b0;
    fetch_addr = '0;
    eng_rst    = 1'b1;
    res_valid  = 1'b0;
    res_data   = '0;
    resp_valid = 1'b0;
    resp_err   = 2'd0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          req0_ready = ~gnt;
          req1_ready = gnt;
          state_n    = S_CHECK;
        end
      end
      S_CHECK: state_n = cfg_bad ? S_REJECT : S_DIV;
      S_DIV: begin
        if (!div_step)
          state_n = ((rem_r != 8'd0) || (o_next_sq > 12'd64)) ? S_REJECT : S_ENG_RST;
      end
      S_REJECT: begin
        resp_valid = 1'b1;
        resp_err   = 2'd1;
        state_n    = S_IDLE;
      end
      S_ENG_RST: state_n = S_LOAD;
      S_LOAD: begin
        eng_rst = 1'b0;
        // One extra cycle after the last fetch lets the final read data reach the engine.
        if ({5'd0, k_r} < n_sq) begin
          fetch_a_en = 1'b1;
          fetch_b_en = {5'd0, k_r} < m_sq;
          fetch_addr = k_r[5:0];
        end else begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        eng_rst   = 1'b0;
        res_valid = eng_done;
        res_data  = eng_done ? eng_final_out : '0;
        if (run_done || run_tmo) state_n = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_r;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign fetch_sel = grant_r;
  assign res_id    = grant_r;
  assign resp_id   = grant_r;
  assign eng_N1    = n_r;
  assign eng_M1    = m_r;
  assign eng_S1    = s_r;
  assign eng_P1    = p_r;
  assign eng_O1    = o_r;
  assign eng_a_in  = mem_a_rdata;
  assign eng_b_in  = mem_b_rdata;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// tb/tb_conv_job_scheduler.sv - table-driven bench for conv_job_scheduler
// A small engine stand-in answers with beats 0x100+j; a negedge monitor logs every output event.
module tb_conv_job_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [23:0] req0_cfg, req1_cfg;
  logic        fetch_sel, fetch_a_en, fetch_b_en;
  logic [5:0]  fetch_addr;
  logic [15:0] mem_a_rdata, mem_b_rdata, eng_a_in, eng_b_in, eng_final_out, res_data;
  logic        eng_rst, eng_done, res_valid, res_id, resp_valid, resp_id, busy;
  logic [5:0]  eng_N1, eng_M1, eng_S1, eng_P1, eng_O1;
  logic [1:0]  resp_err;

  always #5 CLK = ~CLK;

  conv_job_scheduler #(.Width(16), .TIMEOUT(100)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_cfg(req0_cfg), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cfg(req1_cfg), .req1_ready(req1_ready),
    .fetch_sel(fetch_sel), .fetch_addr(fetch_addr), .fetch_a_en(fetch_a_en), .fetch_b_en(fetch_b_en),
    .mem_a_rdata(mem_a_rdata), .mem_b_rdata(mem_b_rdata), .eng_rst(eng_rst),
    .eng_N1(eng_N1), .eng_M1(eng_M1), .eng_S1(eng_S1), .eng_P1(eng_P1), .eng_O1(eng_O1),
    .eng_a_in(eng_a_in), .eng_b_in(eng_b_in), .eng_final_out(eng_final_out), .eng_done(eng_done),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err), .busy(busy)
  );

  typedef struct {
    logic       id;
    logic [5:0] n, m, s, p;
    int         err, o, nfetch, nb, nbeats;
  } job_t;

  typedef struct {
    logic       id;
    logic [1:0] err;
    int         cyc;
    logic [5:0] o;
    logic       rst;
  } resp_t;

  resp_t resp_q[$];
  int    addr_q[$], data_q[$];
  bit    b_q[$], rid_q[$], gnt_q[$];
  int    cyc = 0, falls = 0, last_fetch_cyc = 0;
  logic  prev_rst = 1'b1;
  int    n_cmp = 0, n_fail = 0;
  bit    eng_en = 1'b1;
  int    quiet = 0, seq = 0;
  job_t  jobs[9];
  job_t  tj;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (resp_valid) resp_q.push_back('{resp_id, resp_err, cyc, eng_O1, eng_rst});
    if (fetch_a_en) begin
      addr_q.push_back(int'(fetch_addr));
      b_q.push_back(fetch_b_en);
      last_fetch_cyc = cyc;
    end
    if (res_valid) begin
      data_q.push_back(int'(res_data));
      rid_q.push_back(res_id);
    end
    if (req0_ready) gnt_q.push_back(1'b0);
    if (req1_ready) gnt_q.push_back(1'b1);
    if (prev_rst && !eng_rst) falls++;
    prev_rst = eng_rst;
  end

  // Engine stand-in: after loading, a result every other cycle.
  always @(posedge CLK) begin
    #1;
    if (eng_rst || !eng_en) begin
      quiet = 0; seq = 0; eng_done = 1'b0;
    end else if (fetch_a_en) begin
      quiet = 0; eng_done = 1'b0;
    end else begin
      quiet++;
      if (quiet >= 2 && quiet % 2 == 0) begin
        eng_done = 1'b1;
        eng_final_out = 16'(16'h100 + seq);
        seq++;
      end else begin
        eng_done = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic string nm(input int idx, input string s);
    return $sformatf("job%0d_%s", idx, s);
  endfunction

  function automatic logic [23:0] pack(input job_t j);
    return {j.n, j.m, j.s, j.p};
  endfunction

  task automatic clear_logs();
    resp_q.delete(); addr_q.delete(); b_q.delete();
    data_q.delete(); rid_q.delete(); gnt_q.delete();
    falls = 0;
  endtask

  task automatic run_job(input job_t j, input bit both);
    clear_logs();
    @(posedge CLK); #1;
    if (j.id || both) begin req1_valid = 1'b1; req1_cfg = pack(j); end
    if (!j.id || both) begin req0_valid = 1'b1; req0_cfg = pack(j); end
    for (int t = 0; t < 20; t++) begin
      @(posedge CLK);
      if (gnt_q.size() > 0) break;
    end
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge CLK);
      if (resp_q.size() > 0) break;
    end
    @(posedge CLK);
  endtask

  task automatic check_job(input job_t j, input int idx);
    int bad_pat, bad_dat, nb;
    bad_pat = 0; bad_dat = 0; nb = 0;
    chk(nm(idx, "grant_cnt"), gnt_q.size(), 1);
    if (gnt_q.size() > 0) chk(nm(idx, "grant"), int'(gnt_q[0]), int'(j.id));
    chk(nm(idx, "resp_cnt"), resp_q.size(), 1);
    if (resp_q.size() > 0) begin
      chk(nm(idx, "resp_id"), int'(resp_q[0].id), int'(j.id));
      chk(nm(idx, "resp_err"), int'(resp_q[0].err), j.err);
      if (j.o != 0) chk(nm(idx, "eng_O1"), int'(resp_q[0].o), j.o);
    end
    foreach (addr_q[i]) begin
      if (b_q[i]) nb++;
      if (addr_q[i] != i || b_q[i] != (i < int'(j.m) * int'(j.m))) bad_pat++;
    end
    foreach (data_q[i])
      if (data_q[i] != 'h100 + i || rid_q[i] != j.id) bad_dat++;
    chk(nm(idx, "fetch_cnt"), addr_q.size(), j.nfetch);
    chk(nm(idx, "b_en_cnt"), nb, j.nb);
    chk(nm(idx, "fetch_pattern_bad"), bad_pat, 0);
    chk(nm(idx, "beats"), data_q.size(), j.nbeats);
    chk(nm(idx, "beat_data_bad"), bad_dat, 0);
    chk(nm(idx, "eng_rst_release"), falls, (j.err == 1) ? 0 : 1);
  endtask

  initial begin
    RST = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_cfg = '0; req1_cfg = '0;
    mem_a_rdata = 16'hA5A5; mem_b_rdata = 16'h5A5A;
    eng_done = 1'b0; eng_final_out = '0;

    //          id  N  M  S  P  err O  fetch b  beats
    jobs[0] = '{1'b0, 4, 2, 2, 0, 0, 2, 16, 4, 4};
    jobs[1] = '{1'b1, 8, 3, 1, 1, 1, 0, 0, 0, 0};
    jobs[2] = '{1'b0, 5, 2, 2, 0, 1, 0, 0, 0, 0};
    jobs[3] = '{1'b0, 5, 1, 2, 0, 0, 3, 25, 1, 9};
    jobs[4] = '{1'b1, 0, 1, 1, 0, 1, 0, 0, 0, 0};
    jobs[5] = '{1'b1, 4, 2, 0, 0, 1, 0, 0, 0, 0};
    jobs[6] = '{1'b0, 2, 3, 1, 0, 1, 0, 0, 0, 0};
    jobs[7] = '{1'b1, 2, 3, 1, 1, 0, 2, 4, 4, 4};
    jobs[8] = '{1'b0, 8, 8, 1, 0, 0, 1, 64, 64, 1};

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", int'(busy), 0);
    chk("rst_eng_rst", int'(eng_rst), 1);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_fetch_a_en", int'(fetch_a_en), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_eng_O1", int'(eng_O1), 0);
    chk("rst_req0_ready", int'(req0_ready), 0);
    chk("pass_a", int'(eng_a_in), 'hA5A5);
    chk("pass_b", int'(eng_b_in), 'h5A5A);

    for (int i = 0; i < 9; i++) begin
      run_job(jobs[i], 1'b0);
      check_job(jobs[i], i);
    end

    // Engine silent: watchdog fires after 100 RUN cycles.
    eng_en = 1'b0;
    tj = '{1'b1, 4, 2, 2, 0, 2, 0, 16, 4, 0};
    run_job(tj, 1'b0);
    check_job(tj, 90);
    if (resp_q.size() > 0) begin
      chk("tmo_latency", resp_q[0].cyc - last_fetch_cyc, 102);
      chk("tmo_eng_rst", int'(resp_q[0].rst), 1);
    end
    eng_en = 1'b1;

    // Fairness: both requesters held valid across four jobs.
    clear_logs();
    tj = '{1'b0, 2, 1, 1, 0, 0, 2, 4, 1, 4};
    @(posedge CLK); #1;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_cfg = pack(tj); req1_cfg = pack(tj);
    for (int t = 0; t < 1000; t++) begin
      @(posedge CLK);
      if (gnt_q.size() >= 4) break;
    end
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge CLK);
      if (resp_q.size() >= 4) break;
    end
    @(posedge CLK);
    chk("fair_grant_cnt", gnt_q.size(), 4);
    chk("fair_resp_cnt", resp_q.size(), 4);
    chk("fair_beats", data_q.size(), 16);
    foreach (gnt_q[i]) chk($sformatf("fair_grant%0d", i), int'(gnt_q[i]), i % 2);
    foreach (resp_q[i]) begin
      chk($sformatf("fair_resp_id%0d", i), int'(resp_q[i].id), i % 2);
      chk($sformatf("fair_resp_err%0d", i), int'(resp_q[i].err), 0);
    end

    // Reset in the middle of LOAD.
    clear_logs();
    @(posedge CLK); #1;
    req0_valid = 1'b1; req0_cfg = pack(jobs[0]);
    for (int t = 0; t < 20; t++) begin
      @(posedge CLK);
      if (gnt_q.size() > 0) break;
    end
    #1 req0_valid = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(posedge CLK);
      if (addr_q.size() >= 3) break;
    end
    chk("midload_reached", int'(addr_q.size() >= 3), 1);
    #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_eng_rst", int'(eng_rst), 1);
    chk("midrst_fetch", int'(fetch_a_en), 0);
    repeat (4) @(posedge CLK);
    chk("midrst_no_resp", resp_q.size(), 0);

    // Pointer is back on req0 even though req0 was granted last.
    run_job(jobs[0], 1'b1);
    check_job(jobs[0], 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
